// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: sizes, FSM state encoding,
// handler vector table and small helpers used by the controller and CPU side.
package int_ctrl_pkg;

    localparam int NSRC  = 4;
    localparam int VEC_W = 10;
    localparam int ID_W  = 2;

    localparam logic [VEC_W-1:0] VEC0 = 10'b1111111011;
    localparam logic [VEC_W-1:0] VEC1 = 10'b1111111110;
    localparam logic [VEC_W-1:0] VEC2 = 10'b1111111101;
    localparam logic [VEC_W-1:0] VEC3 = 10'b0000001010;

    typedef logic [NSRC-1:0]  src_vec_t;
    typedef logic [ID_W-1:0]  src_id_t;
    typedef logic [VEC_W-1:0] vec_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_e;

    // Handler address for a given source index.
    function automatic vec_addr_t vec_of(input src_id_t id);
        vec_addr_t addr;
        case (id)
            2'd0:    addr = VEC0;
            2'd1:    addr = VEC1;
            2'd2:    addr = VEC2;
            default: addr = VEC3;
        endcase
        return addr;
    endfunction

    // One-hot mask selecting a single source bit.
    function automatic src_vec_t id_onehot(input src_id_t id);
        src_vec_t bits;
        bits     = '0;
        bits[id] = 1'b1;
        return bits;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-facing handshake of the interrupt controller: request/vector towards the
// control unit, accept and return-from-interrupt back from it.
interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic      irq_req;
    src_id_t   vec_id;
    vec_addr_t vec_addr;
    logic      cpu_ack;
    logic      reti;

    modport master (
        output irq_req,
        output vec_id,
        output vec_addr,
        input  cpu_ack,
        input  reti
    );

    modport slave (
        input  irq_req,
        input  vec_id,
        input  vec_addr,
        output cpu_ack,
        output reti
    );

endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of the
// lowest set bit (index 0 has the highest priority).
module int_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects request lines into pending bits, applies
// a software mask, presents the highest-priority eligible source to the CPU
// with a stable vector and tracks in-service sources until return-from-interrupt.
// Optional build macro INT_NEST_EN: allows a higher-priority source to preempt
// a handler in service (nested interrupts, in_service may hold several bits).
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  src_vec_t    irq_src,
    input  logic        mask_we,
    input  src_vec_t    mask_wd,
    int_ctrl_if.master  cpu,
    output src_vec_t    pending,
    output src_vec_t    mask,
    output src_vec_t    in_service
);

    int_state_e state_q,      state_d;
    src_vec_t   src_prev_q,   src_prev_d;
    src_vec_t   pending_q,    pending_d;
    src_vec_t   mask_q,       mask_d;
    src_vec_t   in_service_q, in_service_d;
    logic       irq_req_q,    irq_req_d;
    src_id_t    vec_id_q,     vec_id_d;
    vec_addr_t  vec_addr_q,   vec_addr_d;

    src_vec_t   eligible;
    src_vec_t   src_rise;
    src_vec_t   pend_clr;
    src_vec_t   peel_bit;
    logic       win_valid;
    src_id_t    win_id;
    logic       svc_valid;
    src_id_t    svc_id;

    assign eligible = pending_q & mask_q;

    int_prio_enc #(.N(NSRC), .W(ID_W)) u_arb (
        .vec   (eligible),
        .valid (win_valid),
        .idx   (win_id)
    );

    int_prio_enc #(.N(NSRC), .W(ID_W)) u_peel (
        .vec   (in_service_q),
        .valid (svc_valid),
        .idx   (svc_id)
    );

    assign peel_bit = svc_valid ? id_onehot(svc_id) : '0;

    // Rising-edge capture into pending; a same-cycle set beats the ack clear.
    always_comb begin
        src_prev_d = irq_src;
        src_rise   = irq_src & ~src_prev_q;
        pending_d  = (pending_q & ~pend_clr) | src_rise;
        mask_d     = mask_we ? mask_wd : mask_q;
    end

    // Request/service handshake: latch a winner, hold it until ack or withdraw,
    // then wait in service until reti empties the in-service set.
    always_comb begin
        state_d      = state_q;
        irq_req_d    = irq_req_q;
        vec_id_d     = vec_id_q;
        vec_addr_d   = vec_addr_q;
        in_service_d = in_service_q;
        pend_clr     = '0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = REQ;
                    irq_req_d  = 1'b1;
                    vec_id_d   = win_id;
                    vec_addr_d = vec_of(win_id);
                end
            end

            REQ: begin
                if (cpu.cpu_ack) begin
                    pend_clr     = id_onehot(vec_id_q);
                    in_service_d = in_service_q | id_onehot(vec_id_q);
                    irq_req_d    = 1'b0;
                    state_d      = SERVICE;
                end else if (!mask_q[vec_id_q]) begin
                    irq_req_d = 1'b0;
`ifdef INT_NEST_EN
                    state_d   = (in_service_q != '0) ? SERVICE : IDLE;
`else
                    state_d   = IDLE;
`endif
                end
            end

            SERVICE: begin
                if (cpu.reti) begin
                    in_service_d = in_service_q & ~peel_bit;
                    if ((in_service_q & ~peel_bit) == '0) begin
                        state_d = IDLE;
                    end
                end else if (!svc_valid) begin
                    state_d = IDLE;
`ifdef INT_NEST_EN
                end else if (win_valid && (win_id < svc_id)) begin
                    state_d    = REQ;
                    irq_req_d  = 1'b1;
                    vec_id_d   = win_id;
                    vec_addr_d = vec_of(win_id);
`endif
                end
            end

            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            src_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            irq_req_q    <= 1'b0;
            vec_id_q     <= '0;
            vec_addr_q   <= VEC0;
        end else begin
            state_q      <= state_d;
            src_prev_q   <= src_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            irq_req_q    <= irq_req_d;
            vec_id_q     <= vec_id_d;
            vec_addr_q   <= vec_addr_d;
        end
    end

    assign cpu.irq_req  = irq_req_q;
    assign cpu.vec_id   = vec_id_q;
    assign cpu.vec_addr = vec_addr_q;
    assign pending      = pending_q;
    assign mask         = mask_q;
    assign in_service   = in_service_q;

endmodule
